// File: rtl/burst_mem_ctrl.sv
// burst_mem_ctrl: cache-line burst controller between a line-based cache port
// and a word-wide memory with variable latency.
//
// Ports:
//   CLK, RST          clock (rising edge) and asynchronous active-high reset
//   REQ_VALID/READY   line request handshake (REQ_READY high only when idle)
//   REQ_WRITE         1 = write-back, 0 = fill
//   REQ_ADDR          byte address; offset within the line is ignored
//   REQ_WDATA         line to write, word i at [32i+31:32i]
//   RESP_VALID        one-cycle completion pulse for reads and writes
//   RESP_RDATA        last filled line, same word order as REQ_WDATA
//   MEM_RE/MEM_WE     memory read/write enables, held for the whole burst
//   MEM_ADDR          memory word address (0 when no burst is active)
//   MEM_DATA_IN       write word to memory (0 outside a write burst)
//   MEM_VALID         memory beat strobe
//   MEM_DATA_OUT      memory read word, valid while MEM_VALID is high
`timescale 1ns/1ps
module burst_mem_ctrl #(
  parameter int unsigned DELAY_CYCLES = 10,
  parameter int unsigned BURST_LEN    = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_VALID,
  input  logic                    REQ_WRITE,
  input  logic [31:0]             REQ_ADDR,
  input  logic [BURST_LEN*32-1:0] REQ_WDATA,
  output logic                    REQ_READY,
  output logic                    RESP_VALID,
  output logic [BURST_LEN*32-1:0] RESP_RDATA,
  output logic                    MEM_RE,
  output logic                    MEM_WE,
  output logic [31:0]             MEM_ADDR,
  output logic [31:0]             MEM_DATA_IN,
  input  logic                    MEM_VALID,
  input  logic [31:0]             MEM_DATA_OUT
);

  localparam int unsigned BeatW       = $clog2(BURST_LEN);
  // Long enough for any burst the memory may still be running to drain.
  localparam int unsigned QuietCycles = DELAY_CYCLES + BURST_LEN + 1;
  localparam int unsigned QuietW      = $clog2(QuietCycles);
  localparam logic [29:0] LineMask    = 30'((1 << BeatW) - 1);

  typedef enum logic [2:0] {StQuiet, StIdle, StRead, StWrite, StDone} state_e;

  state_e                  state_q;
  logic [QuietW-1:0]       quiet_cnt_q;
  logic [BeatW-1:0]        beat_q;
  logic [29:0]             base_q;
  logic [BURST_LEN*32-1:0] wdata_q;
  logic [BURST_LEN*32-1:0] rdata_q;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic                    mem_re_q;
  logic                    mem_we_q;
  logic                    in_burst;
  logic                    unused_addr_lsb;

  // Byte offset within a word carries no information for this block.
  assign unused_addr_lsb = ^REQ_ADDR[1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StQuiet;
      quiet_cnt_q  <= '0;
      beat_q       <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StQuiet: begin
          if (quiet_cnt_q == QuietW'(QuietCycles - 1)) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
          end else begin
            quiet_cnt_q <= quiet_cnt_q + QuietW'(1);
          end
        end
        StIdle: begin
          if (REQ_VALID) begin
            base_q      <= REQ_ADDR[31:2] & ~LineMask;
            wdata_q     <= REQ_WDATA;
            beat_q      <= '0;
            req_ready_q <= 1'b0;
            if (REQ_WRITE) begin
              state_q  <= StWrite;
              mem_we_q <= 1'b1;
            end else begin
              state_q  <= StRead;
              mem_re_q <= 1'b1;
            end
          end
        end
        StRead, StWrite: begin
          if (MEM_VALID) begin
            if (state_q == StRead) begin
              rdata_q[32*beat_q +: 32] <= MEM_DATA_OUT;
            end
            // Wraps back to 0 on the last beat.
            beat_q <= beat_q + BeatW'(1);
            if (beat_q == BeatW'(BURST_LEN - 1)) begin
              state_q      <= StDone;
              mem_re_q     <= 1'b0;
              mem_we_q     <= 1'b0;
              resp_valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q      <= StIdle;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q      <= StQuiet;
          quiet_cnt_q  <= '0;
          beat_q       <= '0;
          req_ready_q  <= 1'b0;
          resp_valid_q <= 1'b0;
          mem_re_q     <= 1'b0;
          mem_we_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_burst    = (state_q == StRead) || (state_q == StWrite);
  // Base has its beat bits cleared, so OR-ing the beat is the same as adding it.
  assign MEM_ADDR    = in_burst ? {2'b00, base_q | 30'(beat_q)} : 32'h0;
  assign MEM_DATA_IN = (state_q == StWrite) ? wdata_q[32*beat_q +: 32] : 32'h0;

  assign REQ_READY  = req_ready_q;
  assign RESP_VALID = resp_valid_q;
  assign RESP_RDATA = rdata_q;
  assign MEM_RE     = mem_re_q;
  assign MEM_WE     = mem_we_q;

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Testbench for burst_mem_ctrl: a latency memory model, a request driver that
// pushes expected responses into a scoreboard, and a negedge monitor that
// checks bursts and responses against the scoreboard.
`timescale 1ns/1ps
module tb_burst_mem_ctrl;

  localparam int unsigned DELAY  = 10;
  localparam int unsigned BL     = 8;
  localparam int unsigned BW     = BL * 32;
  localparam int unsigned LOG_BL = $clog2(BL);
  localparam int unsigned LAT    = DELAY + BL + 1;

  typedef struct {
    logic          wr;
    int unsigned   line;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;
    longint        resp_cyc;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ_VALID = 1'b0;
  logic          REQ_WRITE = 1'b0;
  logic [31:0]   REQ_ADDR = 32'h0;
  logic [BW-1:0] REQ_WDATA = '0;
  logic          REQ_READY;
  logic          RESP_VALID;
  logic [BW-1:0] RESP_RDATA;
  logic          MEM_RE;
  logic          MEM_WE;
  logic [31:0]   MEM_ADDR;
  logic [31:0]   MEM_DATA_IN;
  logic          MEM_VALID;
  logic [31:0]   MEM_DATA_OUT;

  int            n_checks = 0;
  int            n_fail = 0;
  longint        cyc = 0;
  int            acc_cnt = 0;
  int            mon_beat = 0;
  logic          prev_resp = 1'b0;
  exp_t          sb[$];
  exp_t          mon_f;
  logic [BW-1:0] shadow = '0;

  logic [31:0]   mem [0:511];
  int            mcnt = 0;

  burst_mem_ctrl #(
    .DELAY_CYCLES(DELAY),
    .BURST_LEN   (BL)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ_VALID   (REQ_VALID),
    .REQ_WRITE   (REQ_WRITE),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_WDATA   (REQ_WDATA),
    .REQ_READY   (REQ_READY),
    .RESP_VALID  (RESP_VALID),
    .RESP_RDATA  (RESP_RDATA),
    .MEM_RE      (MEM_RE),
    .MEM_WE      (MEM_WE),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_DATA_IN (MEM_DATA_IN),
    .MEM_VALID   (MEM_VALID),
    .MEM_DATA_OUT(MEM_DATA_OUT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: beats start DELAY+1 edges after the enable is first seen
  // and continue back to back until the controller drops the enable.
  always @(posedge CLK) begin
    if (MEM_WE && MEM_VALID) mem[MEM_ADDR[8:0]] <= MEM_DATA_IN;
    mcnt <= (MEM_RE || MEM_WE) ? mcnt + 1 : 0;
  end
  assign MEM_VALID    = (MEM_RE || MEM_WE) && (mcnt >= int'(DELAY + 1));
  assign MEM_DATA_OUT = MEM_VALID ? mem[MEM_ADDR[8:0]] : 32'h0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [BW-1:0] mk_line(input logic [31:0] first);
    logic [BW-1:0] r;
    for (int i = 0; i < int'(BL); i++) r[32*i +: 32] = first + 32'(i);
    return r;
  endfunction

  // Monitor
  always @(negedge CLK) begin
    if (RST) begin
      check("rst_ctl_zero", BW'({REQ_READY, RESP_VALID, MEM_RE, MEM_WE, MEM_ADDR, MEM_DATA_IN}), '0);
      check("rst_rdata_zero", RESP_RDATA, '0);
      mon_beat = 0;
      prev_resp = 1'b0;
    end else begin
      if (REQ_VALID && REQ_READY) acc_cnt++;
      if (prev_resp) check("ready_after_resp", BW'(REQ_READY), BW'(1));
      prev_resp = RESP_VALID;
      check("re_we_excl", BW'(MEM_RE & MEM_WE), '0);
      check("ready_only_idle", BW'(REQ_READY & (MEM_RE | MEM_WE | RESP_VALID)), '0);
      if (!(MEM_RE || MEM_WE)) check("addr_idle_zero", BW'(MEM_ADDR), '0);
      if (!MEM_WE) check("wdata_idle_zero", BW'(MEM_DATA_IN), '0);
      if (MEM_RE || MEM_WE) begin
        check("sb_nonempty_in_burst", BW'(sb.size() != 0), BW'(1));
        if (sb.size() != 0) begin
          mon_f = sb[0];
          check("burst_line", BW'(MEM_ADDR >> LOG_BL), BW'(mon_f.line));
          check("burst_dir", BW'({MEM_WE, MEM_RE}), BW'({mon_f.wr, ~mon_f.wr}));
          if (MEM_VALID) begin
            check("beat_addr", BW'(MEM_ADDR), BW'((mon_f.line << LOG_BL) + 32'(mon_beat)));
            if (MEM_WE) check("beat_wdata", BW'(MEM_DATA_IN), BW'(mon_f.wdata[32*mon_beat +: 32]));
            mon_beat++;
          end
        end
      end
      if (RESP_VALID) begin
        check("sb_nonempty_at_resp", BW'(sb.size() != 0), BW'(1));
        check("done_mem_quiet", BW'({MEM_RE, MEM_WE}), '0);
        if (sb.size() != 0) begin
          mon_f = sb.pop_front();
          check("resp_cycle", BW'(cyc), BW'(mon_f.resp_cyc));
          check("resp_rdata", RESP_RDATA, mon_f.rdata);
          check("resp_beats", BW'(mon_beat), BW'(BL));
        end
        mon_beat = 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic count_quiet(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!REQ_READY && n < 100);
    check(name, BW'(n), BW'(LAT));
  endtask

  // Leaves REQ_VALID high; the caller decides when to drop it.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [BW-1:0] wd,
                       input logic [BW-1:0] exp_rd);
    exp_t e;
    int   n;
    REQ_VALID = 1'b1;
    REQ_WRITE = wr;
    REQ_ADDR  = addr;
    REQ_WDATA = wd;
    n = 0;
    while (!REQ_READY && n < 200) begin
      tick();
      n++;
    end
    check("accept_ready", BW'(REQ_READY), BW'(1));
    if (REQ_READY) begin
      e.wr       = wr;
      e.line     = addr >> (2 + LOG_BL);
      e.wdata    = wd;
      e.resp_cyc = cyc + 1 + longint'(LAT);
      if (wr) begin
        e.rdata = shadow;
      end else begin
        e.rdata = exp_rd;
        shadow  = exp_rd;
      end
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check("drain", BW'(sb.size()), '0);
    sb.delete();
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    for (int i = 0; i < int'(BL); i++) begin
      mem[256 + i] = 32'hA0 + 32'(i);
      mem[128 + i] = 32'hC0 + 32'(i);
    end

    // Power-up reset and QUIET interval
    repeat (3) tick();
    RST = 1'b0;
    count_quiet("quiet_after_por");

    // Fill: line at word 0x100
    issue(1'b0, 32'h400, '0, mk_line(32'hA0));
    REQ_VALID = 1'b0;
    wait_drain();

    // Write-back: unaligned address inside the same line
    issue(1'b1, 32'h41C, mk_line(32'hB0), '0);
    REQ_VALID = 1'b0;
    wait_drain();
    for (int i = 0; i < int'(BL); i++) check("wb_mem", BW'(mem[256 + i]), BW'(32'hB0 + 32'(i)));

    // Back-to-back with REQ_VALID held: write then read of the same line
    acc0 = acc_cnt;
    issue(1'b1, 32'h404, mk_line(32'hD0), '0);
    REQ_WRITE = 1'b0;
    issue(1'b0, 32'h410, '0, mk_line(32'hD0));
    REQ_VALID = 1'b0;
    wait_drain();
    check("b2b_accepts", BW'(acc_cnt - acc0), BW'(2));

    // Reset in the middle of a read burst
    issue(1'b0, 32'h200, '0, mk_line(32'hC0));
    REQ_VALID = 1'b0;
    begin
      int n;
      n = 0;
      while (mon_beat != 3 && n < 100) begin
        tick();
        n++;
      end
      check("reached_beat3", BW'(mon_beat), BW'(3));
    end
    RST = 1'b1;
    sb.delete();
    shadow = '0;
    #1;
    check("rst_async_ctl", BW'({REQ_READY, RESP_VALID, MEM_RE, MEM_WE}), '0);
    check("rst_async_mem", BW'({MEM_ADDR, MEM_DATA_IN}), '0);
    check("rst_async_rdata", RESP_RDATA, '0);
    repeat (2) tick();
    RST = 1'b0;
    count_quiet("quiet_after_rst");
    issue(1'b0, 32'h200, '0, mk_line(32'hC0));
    REQ_VALID = 1'b0;
    wait_drain();

    // Busy: requests toggled while a read is in flight must be ignored
    acc0 = acc_cnt;
    issue(1'b0, 32'h400, '0, mk_line(32'hD0));
    REQ_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      REQ_VALID = ~REQ_VALID;
      REQ_WRITE = i[1];
      REQ_ADDR  = 32'h600 + 32'(i * 32);
      tick();
    end
    REQ_VALID = 1'b0;
    wait_drain();
    repeat (30) tick();
    check("busy_accepts", BW'(acc_cnt - acc0), BW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_mem_ctrl.md
BURST_MEM_CTRL -- requirements
Module: burst_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DELAY_CYCLES, default 10: memory latency from the request edge to the first valid beat.
REQ-002 The block SHALL have parameter BURST_LEN, default 8: number of 32-bit words per line; power of two, at least 2.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port REQ_VALID, input, 1 bit: line request from the cache.
REQ-006 The block SHALL have port REQ_WRITE, input, 1 bit: 1 = write-back, 0 = fill.
REQ-007 The block SHALL have port REQ_ADDR, input, 32 bits: byte address; low 2+log2(BURST_LEN) bits are ignored.
REQ-008 The block SHALL have port REQ_WDATA, input, BURST_LEN*32 bits: line to write; word i in bits [32i+31:32i].
REQ-009 The block SHALL have port REQ_READY, output, 1 bit: request accepted on an edge where REQ_VALID and REQ_READY are both 1.
REQ-010 The block SHALL have port RESP_VALID, output, 1 bit: one-cycle completion pulse, for both reads and writes.
REQ-011 The block SHALL have port RESP_RDATA, output, BURST_LEN*32 bits: filled line, using the REQ_WDATA word order.
REQ-012 The block SHALL have port MEM_RE, output, 1 bit: memory read enable.
REQ-013 The block SHALL have port MEM_WE, output, 1 bit: memory write enable.
REQ-014 The block SHALL have port MEM_ADDR, output, 32 bits: memory word address.
REQ-015 The block SHALL have port MEM_DATA_IN, output, 32 bits: write word to memory.
REQ-016 The block SHALL have port MEM_VALID, input, 1 bit: memory beat valid.
REQ-017 The block SHALL have port MEM_DATA_OUT, input, 32 bits: memory read word, valid while MEM_VALID=1.

Function
REQ-018 The block SHALL use states QUIET, IDLE, READ, WRITE and DONE; all outputs except RESP_RDATA SHALL be Moore outputs of the state and the beat counter.
REQ-019 REQ_READY SHALL be 1 only in IDLE.
REQ-020 On acceptance, the block SHALL latch the base word address, REQ_WRITE and REQ_WDATA, then go to WRITE if REQ_WRITE=1, else READ.
REQ-021 Base word address SHALL be REQ_ADDR[31:2] with the low log2(BURST_LEN) bits cleared.
REQ-022 MEM_RE SHALL be 1 only in READ, and MEM_WE SHALL be 1 only in WRITE; the two SHALL never be 1 together, and SHALL be held constant for the whole state.
REQ-023 MEM_ADDR SHALL equal base + beat, where beat is a log2(BURST_LEN)-bit counter cleared on acceptance; MEM_ADDR SHALL be 0 outside READ and WRITE.
REQ-024 The beat counter SHALL increment on each rising edge with MEM_VALID=1 in READ or WRITE.
REQ-025 In WRITE, MEM_DATA_IN SHALL equal latched word[beat] at all times; outside WRITE it SHALL be 0.
REQ-026 In READ, on each edge with MEM_VALID=1, the block SHALL store MEM_DATA_OUT into RESP_RDATA word[beat].
REQ-027 The edge with MEM_VALID=1 and beat=BURST_LEN-1 SHALL move READ or WRITE to DONE; MEM_RE and MEM_WE SHALL drop after that same edge.
REQ-028 DONE SHALL last exactly one cycle with RESP_VALID=1, then go to IDLE.
REQ-029 Latency: for acceptance on edge N, RESP_VALID SHALL be 1 in the cycle after edge N+DELAY_CYCLES+BURST_LEN+1, and REQ_READY SHALL be 1 again one cycle later.
REQ-030 RESP_RDATA SHALL hold its value until the next read beat, and SHALL be unchanged by writes.
REQ-031 MEM_VALID SHALL be ignored in QUIET, IDLE and DONE.
REQ-032 REQ_VALID SHALL be ignored while REQ_READY=0; no request is queued.
REQ-033 QUIET SHALL count DELAY_CYCLES+BURST_LEN+1 cycles with REQ_READY=0 and all memory outputs 0, then go to IDLE, so that a memory burst already in progress drains first.

Reset
REQ-034 While RST=1, the state SHALL be QUIET, the QUIET counter and beat counter SHALL be 0, RESP_RDATA SHALL be 0, and all outputs SHALL be 0; this SHALL hold even when RST is asserted mid-burst.
REQ-035 After RST is released, the block SHALL first raise REQ_READY on the edge that completes the QUIET count of REQ-033.

Verification
REQ-036 Fill test: after QUIET, with memory words 0x100..0x107 = 0xA0..0xA7, REQ_ADDR=0x400, REQ_WRITE=0 -> MEM_ADDR steps 0x100..0x107, RESP_RDATA words = 0xA0..0xA7, and RESP_VALID occurs 19 cycles after acceptance.
REQ-037 Write-back test: REQ_ADDR=0x41C, REQ_WRITE=1, REQ_WDATA words 0xB0..0xB7 -> MEM_WE=1 for the whole burst, memory 0x100..0x107 = 0xB0..0xB7, and RESP_RDATA is unchanged.
REQ-038 Back-to-back test: REQ_VALID held high with a write followed by a read of the same line -> exactly two acceptances, the read returns the written data, and MEM_RE/MEM_WE are 0 for at least one cycle between the bursts.
REQ-039 Reset mid-burst test: RST pulses at beat 3 of a read -> outputs are 0 immediately, REQ_READY=0 for 19 cycles after release, and a following read returns correct data.
REQ-040 Busy test: REQ_VALID toggled with new addresses during READ -> those requests are ignored, MEM_ADDR stays on the original line, and there is a single RESP_VALID.
